// File: rtl/led_matrix_rx.sv
// HUB75 receiver: samples the matrix bus, rebuilds each latched row into
// a column-ordered pixel stream tagged with row address and bit-plane.
module led_matrix_rx #(
  parameter int COLS     = 64,
  parameter int ROW_BITS = 5,
  parameter int SYNC     = 2
) (
  input  logic                clk_27MHz,
  input  logic                rst_n,
  input  logic                hub_clk,
  input  logic                hub_latch,
  input  logic                hub_oe,
  input  logic [ROW_BITS-1:0] hub_row,
  input  logic [2:0]          hub_rgb1,
  input  logic [2:0]          hub_rgb2,
  output logic                px_valid,
  input  logic                px_ready,
  output logic [5:0]          px_x,
  output logic [ROW_BITS-1:0] px_row,
  output logic [2:0]          px_rgb1,
  output logic [2:0]          px_rgb2,
  output logic [7:0]          px_plane,
  output logic                px_last,
  output logic                overrun,
  output logic                col_err,
  input  logic                err_clr
);

  // Pixel port handshake: a beat transfers on a rising clk_27MHz edge where
  // px_valid & px_ready; while px_valid is high and px_ready is low every
  // px_* field holds its value, and px_valid never drops without a transfer.

  // Bus word layout: {clk, latch, oe, row, rgb1, rgb2}
  localparam int BW = 9 + ROW_BITS;
  localparam int CW = $clog2(COLS + 2);
  localparam int IW = $clog2(COLS);
  localparam logic [CW-1:0] CNT_FULL = CW'(COLS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(COLS + 1);
  localparam logic [5:0]    X_LAST   = 6'(COLS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [BW-1:0] bus_in;
  logic [BW-1:0] cur;
  logic [BW-1:0] hist_q, hist_d;

  assign bus_in = {hub_clk, hub_latch, hub_oe, hub_row, hub_rgb1, hub_rgb2};

  generate
    if (SYNC == 0) begin : g_nosync
      assign cur = bus_in;
    end else begin : g_sync
      logic [BW-1:0] sync_q [SYNC];
      logic [BW-1:0] sync_d [SYNC];

      // Shift the whole bus word down the synchronizer chain together
      always_comb begin
        sync_d[0] = bus_in;
        for (int i = 1; i < SYNC; i++) sync_d[i] = sync_q[i-1];
      end

      // Synchronizer flops, cleared by reset
      always_ff @(posedge clk_27MHz or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
        end else begin
          for (int i = 0; i < SYNC; i++) sync_q[i] <= sync_d[i];
        end
      end

      assign cur = sync_q[SYNC-1];
    end
  endgenerate

  assign hist_d = cur;

  // Field extraction: data and row come from the current stage, edges
  // compare current against the history stage.
  logic                cur_clk, cur_latch;
  logic [ROW_BITS-1:0] cur_row;
  logic [5:0]          cur_rgb;
  logic                clk_rise, latch_rise;
  logic                bus_unused;

  assign cur_clk    = cur[BW-1];
  assign cur_latch  = cur[BW-2];
  assign cur_row    = cur[ROW_BITS+5:6];
  assign cur_rgb    = cur[5:0];
  assign clk_rise   = cur_clk & ~hist_q[BW-1];
  assign latch_rise = cur_latch & ~hist_q[BW-2];
  // oe is carried for alignment only; history of data bits is not needed
  assign bus_unused = ^{cur[BW-3], hist_q[BW-3:0]};

  logic [CW-1:0]       cnt_q, cnt_d, cnt_base;
  logic [5:0]          cap_q [COLS];
  logic [5:0]          cap_d [COLS];
  logic [5:0]          drain_q [COLS];
  logic [5:0]          drain_d [COLS];
  logic [0:0]          state_q, state_d;
  logic [5:0]          x_q, x_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [7:0]          plane_q, plane_d, plane_next;
  logic [7:0]          tplane_q, tplane_d;
  logic                ovr_q, ovr_d, colerr_q, colerr_d;
  logic                new_ovr, new_colerr, at_last;

  // Capture: write shifted columns into the capture buffer; a latch
  // restarts the count so a coincident shift edge lands in column 0.
  always_comb begin
    cap_d    = cap_q;
    cnt_base = latch_rise ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (clk_rise) begin
      if (cnt_base < CNT_FULL) cap_d[cnt_base[IW-1:0]] = cur_rgb;
      if (cnt_base != CNT_SAT) cnt_d = cnt_base + CW'(1);
    end
  end

  // Latch decision, plane tracking and drain FSM
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    drain_d    = drain_q;
    row_d      = row_q;
    plane_d    = plane_q;
    tplane_d   = tplane_q;
    plane_next = plane_q;
    new_ovr    = 1'b0;
    new_colerr = 1'b0;
    at_last    = (x_q == X_LAST);

    if (state_q == ST_SEND && px_ready) begin
      if (at_last) begin
        state_d = ST_IDLE;
        x_d     = '0;
      end else begin
        x_d = x_q + 6'd1;
      end
    end

    if (latch_rise) begin
      if (cur_row == '0) plane_next = plane_q + 8'd1;
      plane_d = plane_next;
      if (cnt_q != CNT_FULL) begin
        new_colerr = 1'b1;
      end else if (state_q != ST_IDLE) begin
        new_ovr = 1'b1;
      end else begin
        drain_d  = cap_q;
        row_d    = cur_row;
        tplane_d = plane_next;
        state_d  = ST_SEND;
        x_d      = '0;
      end
    end

    // A fresh error in the clearing cycle keeps the flag set
    ovr_d    = (ovr_q & ~err_clr) | new_ovr;
    colerr_d = (colerr_q & ~err_clr) | new_colerr;
  end

  // Control and status registers
  always_ff @(posedge clk_27MHz or negedge rst_n) begin
    if (!rst_n) begin
      hist_q   <= '0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      x_q      <= '0;
      row_q    <= '0;
      plane_q  <= 8'hFF;
      tplane_q <= '0;
      ovr_q    <= 1'b0;
      colerr_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      x_q      <= x_d;
      row_q    <= row_d;
      plane_q  <= plane_d;
      tplane_q <= tplane_d;
      ovr_q    <= ovr_d;
      colerr_q <= colerr_d;
    end
  end

  // Pixel storage; contents are only visible while px_valid is high
  always_ff @(posedge clk_27MHz) begin
    cap_q   <= cap_d;
    drain_q <= drain_d;
  end

  assign px_valid = (state_q == ST_SEND);
  assign px_x     = x_q;
  assign px_row   = row_q;
  assign px_plane = tplane_q;
  assign px_rgb1  = px_valid ? drain_q[x_q[IW-1:0]][5:3] : 3'b000;
  assign px_rgb2  = px_valid ? drain_q[x_q[IW-1:0]][2:0] : 3'b000;
  assign px_last  = px_valid & at_last;
  assign overrun  = ovr_q;
  assign col_err  = colerr_q;

endmodule

// File: tb/tb_led_matrix_rx.sv
// Bench for led_matrix_rx: HUB75 bus from an unrelated bus clock, expected
// beats built from the shifted column data and the plane/row rules.
`timescale 1ns/100ps
module tb_led_matrix_rx;

  localparam int COLS = 64;
  localparam int RB   = 5;
  localparam int W    = 26;

  // ---------------- clock / reset ----------------
  logic clk_27MHz = 1'b0;
  logic bclk      = 1'b0;
  logic rst_n     = 1'b0;
  always #18.5 clk_27MHz = ~clk_27MHz;
  always #37.3 bclk = ~bclk;

  logic          hub_clk = 1'b0, hub_latch = 1'b0, hub_oe = 1'b1;
  logic [RB-1:0] hub_row = '0;
  logic [2:0]    hub_rgb1 = '0, hub_rgb2 = '0;
  logic          px_ready = 1'b0, err_clr = 1'b0;
  logic          px_valid, px_last, overrun, col_err;
  logic [5:0]    px_x;
  logic [RB-1:0] px_row;
  logic [2:0]    px_rgb1, px_rgb2;
  logic [7:0]    px_plane;

  led_matrix_rx #(.COLS(COLS), .ROW_BITS(RB), .SYNC(2)) dut (
    .clk_27MHz(clk_27MHz), .rst_n(rst_n),
    .hub_clk(hub_clk), .hub_latch(hub_latch), .hub_oe(hub_oe),
    .hub_row(hub_row), .hub_rgb1(hub_rgb1), .hub_rgb2(hub_rgb2),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_row(px_row),
    .px_rgb1(px_rgb1), .px_rgb2(px_rgb2), .px_plane(px_plane),
    .px_last(px_last), .overrun(overrun), .col_err(col_err), .err_clr(err_clr)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int m_plane = 255;
  bit m_col_err = 1'b0, m_overrun = 1'b0;
  bit rand_ready = 1'b0, ready_lvl = 1'b1;

  function automatic logic [W-1:0] pack(input logic [5:0] x, input logic [RB-1:0] row,
                                        input logic [2:0] a, input logic [2:0] b,
                                        input logic [7:0] pl, input logic last);
    return {x, row, a, b, pl, last};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sink ready: fixed level or random 75% duty
  initial begin
    forever begin
      @(posedge clk_27MHz);
      #1 px_ready = rand_ready ? ($urandom_range(3) != 0) : ready_lvl;
    end
  end

  // Beat monitor: compares each transfer with the expected queue and
  // checks that a stalled beat is held unchanged.
  logic [W-1:0] held;
  bit stalled = 1'b0;
  always @(negedge clk_27MHz) begin
    logic [W-1:0] obs;
    logic [W-1:0] e;
    obs = pack(px_x, px_row, px_rgb1, px_rgb2, px_plane, px_last);
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", 64'(px_valid), 64'(1));
        check("hold_fields", 64'(obs), 64'(held));
      end
      if (px_valid && px_ready) begin
        check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", 64'(obs), 64'(e));
        end
      end
      stalled = px_valid && !px_ready;
      held    = obs;
    end
  end

  // ---------------- driver tasks ----------------
  // Shift n columns then latch row; the model decides the row's fate at the latch.
  task automatic send_row(input int row, input int n, input bit rnd);
    logic [2:0] d1 [COLS];
    logic [2:0] d2 [COLS];
    logic [2:0] v1, v2;
    for (int c = 0; c < n; c++) begin
      @(posedge bclk);
      hub_clk = 1'b0;
      hub_oe  = 1'($urandom_range(1));
      v1 = rnd ? 3'($urandom_range(7)) : 3'(c);
      v2 = rnd ? 3'($urandom_range(7)) : ~3'(c);
      hub_rgb1 = v1;
      hub_rgb2 = v2;
      if (c < COLS) begin
        d1[c] = v1;
        d2[c] = v2;
      end
      @(posedge bclk);
      hub_clk = 1'b1;
    end
    @(posedge bclk);
    hub_clk = 1'b0;
    hub_row = RB'(row);
    @(posedge bclk);
    hub_latch = 1'b1;
    if (row == 0) m_plane = (m_plane + 1) % 256;
    if (n != COLS) m_col_err = 1'b1;
    else if (exp_q.size() != 0) m_overrun = 1'b1;
    else begin
      for (int c = 0; c < COLS; c++)
        exp_q.push_back(pack(6'(c), RB'(row), d1[c], d2[c], 8'(m_plane), c == COLS - 1));
    end
    @(posedge bclk);
    hub_latch = 1'b0;
    repeat (3) @(posedge bclk);
    check("col_err", 64'(col_err), 64'(m_col_err));
    check("overrun", 64'(overrun), 64'(m_overrun));
  endtask

  task automatic pulse_err_clr();
    @(posedge clk_27MHz);
    #1 err_clr = 1'b1;
    @(posedge clk_27MHz);
    #1 err_clr = 1'b0;
    m_col_err = 1'b0;
    m_overrun = 1'b0;
    @(negedge clk_27MHz);
    check("clr_col_err", 64'(col_err), 64'(0));
    check("clr_overrun", 64'(overrun), 64'(0));
  endtask

  task automatic wait_drain();
    int budget;
    budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk_27MHz);
      budget--;
    end
    check("drain_done", 64'(exp_q.size()), 64'(0));
    repeat (3) @(negedge clk_27MHz);
    check("idle_after_drain", 64'(px_valid), 64'(0));
  endtask

  // Watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d beats outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int budget;
    // reset state
    repeat (4) @(negedge clk_27MHz);
    check("rst_valid", 64'(px_valid), 64'(0));
    check("rst_x", 64'(px_x), 64'(0));
    check("rst_row", 64'(px_row), 64'(0));
    check("rst_rgb", 64'({px_rgb1, px_rgb2}), 64'(0));
    check("rst_plane", 64'(px_plane), 64'(0));
    check("rst_last", 64'(px_last), 64'(0));
    check("rst_flags", 64'({overrun, col_err}), 64'(0));
    #3 rst_n = 1'b1;
    repeat (4) @(posedge clk_27MHz);

    // basic rows with column pattern: row 0 opens plane 0, then row 5
    send_row(0, COLS, 1'b0);
    send_row(5, COLS, 1'b0);
    wait_drain();

    // two full frames of random data
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 32; r++) send_row(r, COLS, 1'b1);
    wait_drain();

    // advance the plane with dropped row-0 latches until the next one wraps
    while (m_plane != 255) send_row(0, 0, 1'b0);
    pulse_err_clr();
    send_row(0, COLS, 1'b1);
    wait_drain();

    // backpressure then overrun: second row dropped, first row intact
    ready_lvl = 1'b0;
    send_row(7, COLS, 1'b1);
    repeat (200) @(posedge clk_27MHz);
    send_row(8, COLS, 1'b1);
    ready_lvl = 1'b1;
    wait_drain();
    pulse_err_clr();

    // wrong shift counts
    send_row(3, COLS - 1, 1'b1);
    pulse_err_clr();
    send_row(3, COLS + 1, 1'b1);
    pulse_err_clr();

    // random rows with random sink readiness
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) send_row(int'($urandom_range(31)), COLS, 1'b1);
    rand_ready = 1'b0;
    wait_drain();

    // reset in the middle of a drain
    send_row(9, COLS, 1'b1);
    budget = 300;
    while (!(px_valid && px_x == 6'd20) && budget > 0) begin
      @(negedge clk_27MHz);
      budget--;
    end
    check("reached_x20", 64'(px_valid && px_x == 6'd20), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(px_valid), 64'(0));
    check("midrst_x", 64'(px_x), 64'(0));
    exp_q.delete();
    m_plane   = 255;
    m_col_err = 1'b0;
    m_overrun = 1'b0;
    repeat (3) @(negedge clk_27MHz);
    check("midrst_hold_valid", 64'(px_valid), 64'(0));
    #3 rst_n = 1'b1;
    repeat (10) @(negedge clk_27MHz);
    check("post_rst_idle", 64'(px_valid), 64'(0));
    send_row(0, COLS, 1'b1);
    wait_drain();

    repeat (20) @(negedge clk_27MHz);
    check("end_idle", 64'(px_valid), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
